// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result handshake bundle for pipelined_adder.
//               Operand channel : in_valid, in_ready, a, b, cin, sub
//               Result channel  : out_valid, out_ready, sum, cout (+ ovf)
//               Modport "slave" is the adder side, "master" the client side.
//               ovf exists only when ADDER_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;

  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
`else
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit adder/subtractor, carry chain split into STAGES
//               chunks with one chunk resolved per register stage. Each stage
//               has its own valid bit; ready ripples back combinationally so
//               bubbles collapse under backpressure.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - pipelined_adder_if.slave (operand + result channels)
// Option      : ADDER_OVF_EN - adds registered signed-overflow output bus.ovf
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_adder_if.slave     bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage registers: full operand copies travel with the beat; s_q holds
  // the sum chunks resolved so far, c_q the carry out of this stage's chunk.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];

  // Stage inputs (from the operand port for stage 0, else from stage k-1)
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_new [STAGES];
  logic [CHUNK:0]    chunk_sum [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] load;

  // A stage is ready when it, or anything downstream of it, is empty, or
  // the consumer takes the result. Closed form of r[k] = !v[k] | r[k+1].
  genvar gk;
  generate
    for (gk = 0; gk < STAGES; gk++) begin : g_ready
      assign rdy[gk] = bus.out_ready | ~(&v_q[STAGES-1:gk]);
    end
  endgenerate

  always_comb begin
    // Subtraction is A + ~B + ~borrow_in.
    a_src[0] = bus.a;
    b_src[0] = bus.sub ? ~bus.b : bus.b;
    c_src[0] = bus.cin ^ bus.sub;
    s_src[0] = '0;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      v_src[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                   + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, c_src[k]};
      s_new[k] = s_src[k];
      s_new[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];

      // Valid follows upstream whenever the stage is ready; data is only
      // captured for real beats so idle outputs stay quiet.
      load[k] = rdy[k] & v_src[k];
      v_d[k]  = rdy[k] ? v_src[k] : v_q[k];
      a_d[k]  = load[k] ? a_src[k]           : a_q[k];
      b_d[k]  = load[k] ? b_src[k]           : b_q[k];
      s_d[k]  = load[k] ? s_new[k]           : s_q[k];
      c_d[k]  = load[k] ? chunk_sum[k][CHUNK] : c_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic msb_carry;

  // Carry into the MSB recovered from the MSB's own operand and sum bits.
  always_comb begin
    msb_carry = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1] ^ s_new[LAST][WIDTH-1];
    ovf_d     = load[LAST] ? (msb_carry ^ chunk_sum[LAST][CHUNK]) : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Directed self-checking bench for pipelined_adder
//               (WIDTH=16, STAGES=4), plus a short random scoreboard run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  task automatic test_reset();
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b want=0", bus.cout); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
`ifdef ADDER_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
`endif
    rst_n = 1'b1;
  endtask

  // 0xFFFF + 1: carry ripples through every chunk, result after 4 edges.
  task automatic test_ripple_latency();
    bus.out_ready = 1'b1;
    set_beat(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick();                                   // edge 0 accepts
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) begin
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ripple_early_valid edge=%0d got=%b want=0", e, bus.out_valid); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ripple_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h want=0000", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b want=1", bus.cout); end
`ifdef ADDER_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ripple_ovf got=%b want=0", bus.ovf); end
`endif
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ripple_after_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_subtract();
    bus.out_ready = 1'b1;
    set_beat(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
    tick();                                   // edge 0
    set_beat(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1);
    tick();                                   // edge 1
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();                                   // edge 3
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'hFFFE || bus.cout !== 1'b0) begin
      failures++; $display("FAIL sub_5_minus_7 got v=%b sum=%h cout=%b want v=1 sum=fffe cout=0", bus.out_valid, bus.sum, bus.cout); end
    tick();                                   // edge 4
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0001 || bus.cout !== 1'b1) begin
      failures++; $display("FAIL sub_7_minus_5_minus_1 got v=%b sum=%h cout=%b want v=1 sum=0001 cout=1", bus.out_valid, bus.sum, bus.cout); end
    tick();
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_overflow();
    bus.out_ready = 1'b1;
    set_beat(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    set_beat(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
    tick();
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (bus.sum !== 16'h8000 || bus.ovf !== 1'b1 || bus.cout !== 1'b0) begin
      failures++; $display("FAIL ovf_add got sum=%h ovf=%b cout=%b want sum=8000 ovf=1 cout=0", bus.sum, bus.ovf, bus.cout); end
    tick();
    checks++; if (bus.sum !== 16'h7FFF || bus.ovf !== 1'b1 || bus.cout !== 1'b1) begin
      failures++; $display("FAIL ovf_sub got sum=%h ovf=%b cout=%b want sum=7fff ovf=1 cout=1", bus.sum, bus.ovf, bus.cout); end
    tick();
  endtask
`endif

  // Three consecutive beats, one result per cycle, including wrap with cin.
  task automatic test_back_to_back();
    logic [15:0] av [3] = '{16'h1234, 16'h8000, 16'hFFFF};
    logic [15:0] bv [3] = '{16'h4321, 16'h8000, 16'hFFFF};
    logic        cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] sv [3] = '{16'h5555, 16'h0001, 16'hFFFF};
    logic        ov [3] = '{1'b0, 1'b1, 1'b1};
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_beat(1'b1, av[j], bv[j], cv[j], 1'b0);
      tick();
    end
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.sum !== sv[j] || bus.cout !== ov[j]) begin
        failures++; $display("FAIL b2b_beat%0d got v=%b sum=%h cout=%b want v=1 sum=%h cout=%b", j, bus.out_valid, bus.sum, bus.cout, sv[j], ov[j]); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail_valid got=%b want=0", bus.out_valid); end
  endtask

  // Beats a=b=i for i=1..8; out_ready low during cycles 2..7.
  task automatic test_backpressure();
    int          next  = 0;
    int          got   = 0;
    int          c     = 0;
    logic        stall = 1'b0;
    logic [15:0] held  = '0;
    while (got < 8 && c < 60) begin
      bus.out_ready = !(c >= 2 && c <= 7);
      if (next < 8) set_beat(1'b1, 16'(next + 1), 16'(next + 1), 1'b0, 1'b0);
      else          set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #1;
      if (c == 3) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_c3 got=%b want=1", bus.in_ready); end
      end
      if (c == 4) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b want=0", bus.in_ready); end
      end
      if (stall) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.sum !== held) begin
          failures++; $display("FAIL bp_stall_hold cycle=%0d got v=%b sum=%h want v=1 sum=%h", c, bus.out_valid, bus.sum, held); end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.sum !== 16'(2 * (got + 1))) begin
          failures++; $display("FAIL bp_order idx=%0d got=%h want=%h", got, bus.sum, 16'(2 * (got + 1))); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) next++;
      stall = bus.out_valid & ~bus.out_ready;
      held  = bus.sum;
      tick();
      c++;
    end
    checks++; if (got != 8) begin failures++; $display("FAIL bp_count got=%0d want=8", got); end
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int e = 0; e < 5; e++) begin
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate cycle=%0d got=%b want=0", e, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set_beat(1'b1, 16'(j + 1), 16'h0010, 1'b0, 1'b0);
      tick();
    end
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();                                   // first beat now at output
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0011) begin
      failures++; $display("FAIL rstmid_pre got v=%b sum=%h want v=1 sum=0011", bus.out_valid, bus.sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0) begin
      failures++; $display("FAIL rstmid_async got v=%b sum=%h want v=0 sum=0000", bus.out_valid, bus.sum); end
    #4;
    rst_n = 1'b1;
    set_beat(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0);
    tick();                                   // edge 0 accepts
    set_beat(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) begin
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale edge=%0d got=%b want=0", e, bus.out_valid); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h1335 || bus.cout !== 1'b0) begin
      failures++; $display("FAIL rstmid_next got v=%b sum=%h cout=%b want v=1 sum=1335 cout=0", bus.out_valid, bus.sum, bus.cout); end
    tick();
  endtask

  // Random traffic; the model uses plain integer arithmetic.
  task automatic test_random();
    logic [17:0] q [$];
    logic [17:0] exp;
    logic [16:0] add17;
    logic [15:0] ra, rb;
    logic        rc, rs;
    int          sres;
    logic        eovf, ecout;
    logic [15:0] esum;
    for (int c = 0; c < 420; c++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      set_beat((c < 400) ? 1'($urandom_range(3) != 0) : 1'b0, ra, rb, rc, rs);
      bus.out_ready = (c < 400) ? 1'($urandom_range(3) != 0) : 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (rs) begin
          esum  = ra - rb - 16'(rc);
          ecout = ({1'b0, ra} >= ({1'b0, rb} + 17'(rc)));
          sres  = int'($signed(ra)) - int'($signed(rb)) - int'(rc);
        end else begin
          add17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
          esum  = add17[15:0];
          ecout = add17[16];
          sres  = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        end
        eovf = (sres > 32767) || (sres < -32768);
        q.push_back({eovf, ecout, esum});
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_extra cycle=%0d got sum=%h want no beat", c, bus.sum);
        end else begin
          exp = q.pop_front();
          if (bus.sum !== exp[15:0] || bus.cout !== exp[16]) begin
            failures++; $display("FAIL rand_beat cycle=%0d got sum=%h cout=%b want sum=%h cout=%b", c, bus.sum, bus.cout, exp[15:0], exp[16]); end
`ifdef ADDER_OVF_EN
          else if (bus.ovf !== exp[17]) begin
            failures++; $display("FAIL rand_ovf cycle=%0d got=%b want=%b", c, bus.ovf, exp[17]); end
`endif
        end
      end
      tick();
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rand_drain got=%0d pending want=0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ripple_latency();
    test_subtract();
`ifdef ADDER_OVF_EN
    test_overflow();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshakes on input and output. The carry chain is split into STAGES equal chunks, one chunk per register stage, with operands skewed so each stage resolves one chunk. It is the multi-bit, clocked successor to the team's 1-bit full adder and serves as the arithmetic building block for datapaths that need sustained one-result-per-cycle throughput with backpressure.

## Interface
- WIDTH, 16, operand and sum width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and number of carry chunks; WIDTH % STAGES == 0; CHUNK = WIDTH/STAGES.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A−B−cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of bit WIDTH−1 (sub: 1 = no borrow).
- ovf  output  1  signed overflow; present only with ADDER_OVF_EN.

## Operation
- Effective operands: B' = sub ? ~b : b; carry into chunk 0 = sub ? ~cin : cin.
- Stage k (0..STAGES−1) adds chunk k of A and B' plus the carry registered from stage k−1, producing CHUNK sum bits and one carry bit; CHUNK+1-bit addition, no truncation of carry.
- Upper chunks of A and B' and already-computed lower sum chunks travel with the beat through each stage register; no chunk is computed before its input carry is registered.
- Per-stage valid bit v[k]. Stage k ready: r[k] = !v[k] | r[k+1]; r[STAGES] = out_ready. in_ready = r[0].
- Stage k loads from stage k−1 (or from inputs for k = 0) when r[k] is 1; its valid becomes the upstream valid (in_valid & in_ready for k = 0). Stage k holds contents and valid when r[k] is 0.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Output registers are the last stage: sum, cout, ovf, out_valid driven directly from flops.
- Beat transfer on output: out_valid & out_ready at a rising edge. Results leave in acceptance order; no beat is dropped or duplicated.
- a, b, cin, sub are sampled only on an accepting edge; changes while in_ready = 0 have no effect.

## Timing
- Reset (rst_n = 0, asynchronous): all v[k] = 0; out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready reads 1 whenever out_ready=1 or the pipeline is empty, i.e. 1 after reset. Reset mid-operation discards all in-flight beats.
- Release of reset is synchronous to clk: first accepting edge is the first rising edge with rst_n = 1.
- Latency: beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES−1... precisely: visible in the cycle following edge n+STAGES−1 (STAGES clock edges including the accepting one), given no stall.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready has a combinational path from out_ready (depth STAGES AND/OR); no other input→output combinational paths.
- Full pipeline with out_ready = 0: in_ready = 0; out_valid, sum, cout held stable.
- Simultaneous output pop and input push when full: both occur on the same edge, occupancy unchanged.
- Wrap-around: sum is modulo 2^WIDTH; overflow reported only via cout/ovf.

## Configuration
- ADDER_OVF_EN defined: ovf port exists; ovf = carry into bit WIDTH−1 XOR cout, registered alongside sum, reset 0.
- ADDER_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 accepted at edge 0 -> out_valid=1 after edge 3, sum=0x0000, cout=1 (ripple across all chunks).
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1, cin=1 -> sum=0x0001, cout=1.
- Backpressure: stream 8 beats a=i, b=i (i=1..8) with out_ready low for cycles 2–7 -> in_ready falls after 4 beats buffered, outputs 2,4,…,16 in order, none lost or duplicated, sum stable while stalled.
- Overflow (ADDER_OVF_EN): a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Reset mid-stream: 3 beats in flight, pulse rst_n low for half a cycle -> out_valid=0, sum=0 immediately; no stale beat emerges after release; next beat has full 4-cycle latency.
- Random: 10k constrained-random beats with random in_valid/out_ready, STAGES ∈ {1,2,4,16} -> scoreboard matches (a ± b ± cin) mod 2^16 and cout for every beat.
